// File: rtl/parser_arb_pkg.sv
// parser_arb_pkg: shared metadata struct, arbiter constants and counter helper
package parser_arb_pkg;

    typedef struct packed {
        logic [15:0] pkt_len;
        logic [7:0]  in_port;
        logic [31:0] timestamp;
        logic [7:0]  flags;
    } metadata_t;

    localparam int PARSER_ARB_NUM_IN  = 4;
    localparam int PARSER_ARB_EMPTY_W = 6;

    function automatic logic [31:0] stats_cnt_next(input logic [31:0] cnt, input logic [31:0] inc);
        return cnt + inc;
    endfunction

endpackage

// File: rtl/parser_arb_rr_select.sv
// rr_select: combinational rotating-priority picker starting at ptr
module rr_select #(
    parameter int NUM_IN = 4,
    localparam int PW = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     gnt_idx,
    output logic              gnt_any
);

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(k);
        return (s >= (PW+1)'(NUM_IN)) ? PW'(s - (PW+1)'(NUM_IN)) : s[PW-1:0];
    endfunction

    // scan from farthest to nearest so the first requester after ptr wins last
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req[rot(ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rot(ptr, k);
            end
        end
    end

endmodule

// File: rtl/parser_arb.sv
// parser_arb: packet-granular round-robin arbiter in front of the parser
module parser_arb
    import parser_arb_pkg::*;
#(
    parameter int NUM_IN  = PARSER_ARB_NUM_IN,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = PARSER_ARB_EMPTY_W,
    parameter int META_W  = $bits(metadata_t),
    localparam int PW = $clog2(NUM_IN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IN-1:0][DATA_W-1:0]   in_pkt_data,
    input  logic [NUM_IN-1:0]               in_pkt_valid,
    input  logic [NUM_IN-1:0]               in_pkt_sop,
    input  logic [NUM_IN-1:0]               in_pkt_eop,
    input  logic [NUM_IN-1:0][EMPTY_W-1:0]  in_pkt_empty,
    output logic [NUM_IN-1:0]               in_pkt_ready,
    input  logic [NUM_IN-1:0][META_W-1:0]   in_meta_data,
    input  logic [NUM_IN-1:0]               in_meta_valid,
    output logic [NUM_IN-1:0]               in_meta_ready,
    output logic [DATA_W-1:0]               out_pkt_data,
    output logic                            out_pkt_valid,
    output logic                            out_pkt_sop,
    output logic                            out_pkt_eop,
    output logic [EMPTY_W-1:0]              out_pkt_empty,
    input  logic                            out_pkt_ready,
    output logic [META_W-1:0]               out_meta_data,
    output logic                            out_meta_valid,
    input  logic                            out_meta_ready,
    output logic                            grant_valid,
    output logic [PW-1:0]                   grant_idx,
    output logic [31:0]                     stats_pkt,
    output logic [31:0]                     stats_drop
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, win;
    logic              win_any, meta_done, pkt_done, busy;
    logic              m_fire, p_eop_fire, meta_fin, pkt_fin;
    logic [NUM_IN-1:0] eligible, sel, stray;

    assign busy       = state == BUSY && !rst;
    assign eligible   = (state == IDLE && !rst) ? in_meta_valid & in_pkt_valid & in_pkt_sop : '0;
    assign sel        = busy ? NUM_IN'(1) << grant_idx : '0;
    assign stray      = rst ? '0 : in_pkt_valid & ~in_pkt_sop & ~sel;
    assign grant_valid = state == BUSY;

    assign in_pkt_ready  = stray | (sel & {NUM_IN{out_pkt_ready && !pkt_done}});
    assign in_meta_ready = sel & {NUM_IN{out_meta_ready && !meta_done}};

    rr_select #(.NUM_IN(NUM_IN)) u_sel (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_idx (win),
        .gnt_any (win_any)
    );

    // granted requester's streams muxed onto the parser side, zeroed when idle
    always_comb begin
        out_meta_valid = busy && in_meta_valid[grant_idx] && !meta_done;
        out_pkt_valid  = busy && in_pkt_valid[grant_idx] && !pkt_done;
        out_meta_data  = out_meta_valid ? in_meta_data[grant_idx] : '0;
        out_pkt_data   = out_pkt_valid ? in_pkt_data[grant_idx] : '0;
        out_pkt_sop    = out_pkt_valid && in_pkt_sop[grant_idx];
        out_pkt_eop    = out_pkt_valid && in_pkt_eop[grant_idx];
        out_pkt_empty  = out_pkt_valid ? in_pkt_empty[grant_idx] : '0;
        m_fire         = out_meta_valid && out_meta_ready;
        p_eop_fire     = out_pkt_valid && out_pkt_ready && out_pkt_eop;
        meta_fin       = meta_done || m_fire;
        pkt_fin        = pkt_done || p_eop_fire;
    end

    // lock on a winner in IDLE, release once both meta and EOP have transferred
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = win_any ? BUSY : IDLE;
        else state_nxt = (meta_fin && pkt_fin) ? IDLE : BUSY;
    end

    // grant, done flags, round-robin pointer and wrapping statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            meta_done  <= 1'b0;
            pkt_done   <= 1'b0;
            stats_pkt  <= '0;
            stats_drop <= '0;
        end else begin
            state      <= state_nxt;
            stats_pkt  <= stats_cnt_next(stats_pkt, 32'(p_eop_fire));
            stats_drop <= stats_cnt_next(stats_drop, 32'($countones(stray)));
            if (state == IDLE && win_any) begin
                grant_idx <= win;
                rr_ptr    <= (win == PW'(NUM_IN - 1)) ? '0 : win + PW'(1);
                meta_done <= 1'b0;
                pkt_done  <= 1'b0;
            end else if (state == BUSY) begin
                meta_done <= meta_fin;
                pkt_done  <= pkt_fin;
            end
        end
    end

endmodule
